eth_pcs_rx_block_lock: RTL and testbench
========================================

# eth_pcs_rx_block_lock

Parametrised 10GBASE-R receive block-lock and BER monitor. Sits between the RX gearbox and the descrambler/decoder. Examines the 2-bit sync header of each 66-bit block, requests single-bit slips from the gearbox until headers align, declares and holds block lock, and raises high-BER from invalid-header counts over a timed window. Lock thresholds, post-slip settle time and BER window/threshold are parameters, so the same block serves 64-bit and narrower datapaths.

## Interface
- SH_TH, 64: consecutive valid headers needed to acquire lock; also the locked test-window length in blocks.
- SH_INVAL_TH, 16: invalid headers within one locked window that drop lock.
- SLIP_WAIT, 2: accepted blocks ignored after each slip while the gearbox realigns; at least 1.
- BER_WIN, 19531: BER window in clock cycles (125 us at 156.25 MHz).
- BER_TH, 16: invalid headers within one BER window that assert hi-BER.
- W_BER_CNT, 6: width of the saturating management error counter.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  i_sync carries a new block header this cycle; low on gearbox stall cycles.
- i_sync  in  2  sync header. 2'b01 and 2'b10 are valid; 2'b00 and 2'b11 are invalid.
- i_ber_cnt_clr  in  1  clears o_ber_cnt.
- o_slip  out  1  one-cycle pulse asking the gearbox to shift alignment by one bit.
- o_block_lock  out  1  block lock achieved.
- o_hi_ber  out  1  high bit-error-rate condition.
- o_ber_cnt  out  W_BER_CNT  saturating count of invalid headers seen while locked.

## Operation
- All outputs are registered. On reset every output is 0, the FSM is HUNT, and all counters are 0.
- FSM states are HUNT, SLIP_WAIT and LOCKED.
- Counters advance only on i_valid cycles. On non-valid cycles the FSM and block counters hold.
- sh_cnt counts blocks in the current window. sh_inv_cnt counts invalid headers in the current window.
- Window counters are $clog2(SH_TH+1) bits wide and never wrap.

HUNT:
- Invalid header: o_slip=1 next cycle, counters cleared, go to SLIP_WAIT.
- If the SH_TH-th block is valid and all earlier blocks in the window were valid: o_block_lock=1 next cycle, counters cleared, go to LOCKED.

SLIP_WAIT:
- Ignore the header content of the next SLIP_WAIT valid blocks.
- Then go to HUNT with counters cleared.
- o_slip is never re-asserted while in this state.

LOCKED:
- When sh_inv_cnt, including the current block, reaches SH_INVAL_TH: o_block_lock=0 and o_slip=1 next cycle, counters cleared, go to SLIP_WAIT.
- Otherwise, on the SH_TH-th block of the window: counters cleared and the state stays LOCKED.
- If the invalid threshold is reached on the same block that ends the window, the threshold takes priority and lock is lost.

BER monitor:
- A free-running timer of BER_WIN clock cycles counts every cycle, not only valid cycles.
- While o_block_lock=0: ber_win_cnt=0, o_hi_ber=0, and the timer is held at 0.
- While locked, each invalid header increments ber_win_cnt, saturating at BER_TH.
- When ber_win_cnt reaches BER_TH: o_hi_ber=1 next cycle, and it stays 1 until the window ends.
- At window end (timer = BER_WIN-1): o_hi_ber <= (ber_win_cnt including that cycle's block >= BER_TH). ber_win_cnt is then cleared and the timer wraps to 0.

o_ber_cnt:
- Increments on each invalid header while locked and saturates at all-ones.
- i_ber_cnt_clr loads 0. If the clear coincides with a counted invalid header, it loads 1, so the event is not lost.

## Timing
- Latency is one cycle from the deciding i_valid cycle to o_slip, o_block_lock and o_hi_ber.
- o_slip is exactly one cycle wide.
- Minimum spacing between slips is SLIP_WAIT+1 valid blocks.
- Lock acquisition from the first clean block takes SH_TH valid blocks plus one cycle. Gearbox stall cycles add their own count to this.
- Asynchronous reset mid-operation forces every output to 0 immediately.
- After reset deassertion, the first i_valid is treated as block 1 of a HUNT window.

## Test plan
- Reset, then 64 valid headers alternating 01/10 with i_valid=1: o_block_lock rises the cycle after the 64th block, and o_slip stays 0 throughout.
- HUNT with header 00 on block 5: o_slip pulses once on the next cycle. Headers 11 on the following 2 valid blocks cause no slip. 64 clean blocks after that give lock.
- LOCKED with 15 invalid headers in one 64-block window: lock is held. With 16 invalid headers: o_block_lock falls and o_slip pulses the cycle after the 16th invalid header.
- i_valid low for 1 cycle in every 33 during acquisition: lock occurs only after 64 valid blocks, with the FSM frozen on stall cycles.
- BER_WIN=200, 8 invalid headers in each of two consecutive 64-block windows, all inside one BER window: lock is held and o_hi_ber=1 the cycle after the 16th invalid header. A following clean BER window clears o_hi_ber at its end. o_ber_cnt reads 16.
- Drive i_ber_cnt_clr on the same cycle as a locked invalid header: o_ber_cnt=1. Assert i_rst_n=0 while locked: all outputs are 0 immediately.

Source files
------------

// File: rtl/eth_pcs_rx_block_lock.sv
// eth_pcs_rx_block_lock
//   10GBASE-R receive block-lock and BER monitor. Inspects the 2-bit sync
//   header of each 66-bit block, requests single-bit gearbox slips until
//   headers align, declares/holds block lock and flags high BER from the
//   count of invalid headers seen within a timed window.
//
// Ports
//   i_clk          clock
//   i_rst_n        asynchronous active-low reset
//   i_valid        i_sync holds a new block header this cycle (low on stalls)
//   i_sync[1:0]    sync header; 01/10 valid, 00/11 invalid
//   i_ber_cnt_clr  clears o_ber_cnt
//   o_slip         one-cycle request to shift gearbox alignment by one bit
//   o_block_lock   block lock achieved
//   o_hi_ber       high bit-error-rate condition
//   o_ber_cnt      saturating count of invalid headers seen while locked
module eth_pcs_rx_block_lock #(
  parameter int unsigned SH_TH       = 64,
  parameter int unsigned SH_INVAL_TH = 16,
  parameter int unsigned SLIP_WAIT   = 2,
  parameter int unsigned BER_WIN     = 19531,
  parameter int unsigned BER_TH      = 16,
  parameter int unsigned W_BER_CNT   = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [1:0]           i_sync,
  input  logic                 i_ber_cnt_clr,
  output logic                 o_slip,
  output logic                 o_block_lock,
  output logic                 o_hi_ber,
  output logic [W_BER_CNT-1:0] o_ber_cnt
);

  localparam int unsigned CW = $clog2(SH_TH + 1);
  localparam int unsigned WW = $clog2(SLIP_WAIT + 1);
  localparam int unsigned BW = $clog2(BER_TH + 1);
  localparam int unsigned TW = (BER_WIN > 1) ? $clog2(BER_WIN) : 1;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_SLIP_WAIT,
    ST_LOCKED
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        sh_cnt_q, sh_cnt_d;
  logic [CW-1:0]        sh_inv_cnt_q, sh_inv_cnt_d;
  logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
  logic                 slip_q, slip_d;
  logic                 block_lock_q, block_lock_d;
  logic [TW-1:0]        ber_tmr_q, ber_tmr_d;
  logic [BW-1:0]        ber_win_q, ber_win_d;
  logic                 hi_ber_q, hi_ber_d;
  logic [W_BER_CNT-1:0] ber_cnt_q, ber_cnt_d;

  logic          hdr_ok;
  logic [CW-1:0] inv_next;
  logic          win_end;
  logic          inv_hit;
  logic          inv_evt;
  logic [BW-1:0] ber_win_nxt;

  // Valid headers are exactly those with differing bits.
  assign hdr_ok   = i_sync[1] ^ i_sync[0];
  assign inv_next = sh_inv_cnt_q + CW'(!hdr_ok);
  assign win_end  = (sh_cnt_q == CW'(SH_TH - 1));
  assign inv_hit  = (inv_next == CW'(SH_INVAL_TH));

  // State and counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_HUNT;
      sh_cnt_q     <= '0;
      sh_inv_cnt_q <= '0;
      wait_cnt_q   <= '0;
      slip_q       <= 1'b0;
      block_lock_q <= 1'b0;
      ber_tmr_q    <= '0;
      ber_win_q    <= '0;
      hi_ber_q     <= 1'b0;
      ber_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      sh_cnt_q     <= sh_cnt_d;
      sh_inv_cnt_q <= sh_inv_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      slip_q       <= slip_d;
      block_lock_q <= block_lock_d;
      ber_tmr_q    <= ber_tmr_d;
      ber_win_q    <= ber_win_d;
      hi_ber_q     <= hi_ber_d;
      ber_cnt_q    <= ber_cnt_d;
    end
  end

  // Next-state and window counters; everything holds on stall cycles.
  always_comb begin
    state_d      = state_q;
    sh_cnt_d     = sh_cnt_q;
    sh_inv_cnt_d = sh_inv_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    if (i_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          if (!hdr_ok) begin
            state_d      = ST_SLIP_WAIT;
            sh_cnt_d     = '0;
            sh_inv_cnt_d = '0;
            wait_cnt_d   = '0;
          end else if (win_end) begin
            state_d      = ST_LOCKED;
            sh_cnt_d     = '0;
            sh_inv_cnt_d = '0;
          end else begin
            sh_cnt_d = sh_cnt_q + CW'(1);
          end
        end
        ST_SLIP_WAIT: begin
          if (wait_cnt_q == WW'(SLIP_WAIT - 1)) begin
            state_d      = ST_HUNT;
            sh_cnt_d     = '0;
            sh_inv_cnt_d = '0;
            wait_cnt_d   = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + WW'(1);
          end
        end
        ST_LOCKED: begin
          // Invalid threshold wins over a coincident end of window.
          if (inv_hit) begin
            state_d      = ST_SLIP_WAIT;
            sh_cnt_d     = '0;
            sh_inv_cnt_d = '0;
            wait_cnt_d   = '0;
          end else if (win_end) begin
            sh_cnt_d     = '0;
            sh_inv_cnt_d = '0;
          end else begin
            sh_cnt_d     = sh_cnt_q + CW'(1);
            sh_inv_cnt_d = inv_next;
          end
        end
        default: begin
          state_d      = ST_HUNT;
          sh_cnt_d     = '0;
          sh_inv_cnt_d = '0;
          wait_cnt_d   = '0;
        end
      endcase
    end
  end

  // Registered FSM outputs
  always_comb begin
    slip_d = i_valid && (((state_q == ST_HUNT) && !hdr_ok) ||
                         ((state_q == ST_LOCKED) && inv_hit));
    block_lock_d = (state_d == ST_LOCKED);
  end

  // BER monitor and management error counter
  always_comb begin
    inv_evt     = i_valid && !hdr_ok && block_lock_q;
    ber_win_nxt = ber_win_q;
    if (inv_evt && (ber_win_q != BW'(BER_TH))) begin
      ber_win_nxt = ber_win_q + BW'(1);
    end

    // Clearing on the lock-loss cycle keeps o_hi_ber low whenever lock is low.
    if (!block_lock_q || !block_lock_d) begin
      ber_tmr_d = '0;
      ber_win_d = '0;
      hi_ber_d  = 1'b0;
    end else if (ber_tmr_q == TW'(BER_WIN - 1)) begin
      ber_tmr_d = '0;
      ber_win_d = '0;
      hi_ber_d  = (ber_win_nxt >= BW'(BER_TH));
    end else begin
      ber_tmr_d = ber_tmr_q + TW'(1);
      ber_win_d = ber_win_nxt;
      hi_ber_d  = hi_ber_q || (ber_win_nxt == BW'(BER_TH));
    end

    // A clear coinciding with a counted event keeps that event.
    ber_cnt_d = ber_cnt_q;
    if (i_ber_cnt_clr) begin
      ber_cnt_d = inv_evt ? W_BER_CNT'(1) : '0;
    end else if (inv_evt && (ber_cnt_q != '1)) begin
      ber_cnt_d = ber_cnt_q + W_BER_CNT'(1);
    end
  end

  assign o_slip       = slip_q;
  assign o_block_lock = block_lock_q;
  assign o_hi_ber     = hi_ber_q;
  assign o_ber_cnt    = ber_cnt_q;

endmodule

// File: tb/tb_eth_pcs_rx_block_lock.sv
// Directed bench for eth_pcs_rx_block_lock (BER_WIN shortened to 200 cycles).
module tb_eth_pcs_rx_block_lock;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [1:0] sync;
  logic       clr;
  logic       slip;
  logic       lock;
  logic       hi_ber;
  logic [5:0] ber_cnt;

  int unsigned n_cmp     = 0;
  int unsigned n_err     = 0;
  int unsigned slip_seen = 0;

  always #5 clk = ~clk;

  eth_pcs_rx_block_lock #(
    .SH_TH      (64),
    .SH_INVAL_TH(16),
    .SLIP_WAIT  (2),
    .BER_WIN    (200),
    .BER_TH     (16),
    .W_BER_CNT  (6)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid),
    .i_sync       (sync),
    .i_ber_cnt_clr(clr),
    .o_slip       (slip),
    .o_block_lock (lock),
    .o_hi_ber     (hi_ber),
    .o_ber_cnt    (ber_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, sample just after the rising edge.
  task automatic send(input logic v, input logic [1:0] s, input logic c);
    @(negedge clk);
    valid = v;
    sync  = s;
    clr   = c;
    @(posedge clk);
    #1;
    if (slip === 1'b1) slip_seen++;
  endtask

  function automatic logic [1:0] hdr(input int k);
    return k[0] ? 2'b10 : 2'b01;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    sync  = 2'b00;
    clr   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    slip_seen = 0;
  endtask

  task automatic acquire(input string tag);
    for (int k = 1; k <= 64; k++) begin
      send(1'b1, hdr(k), 1'b0);
      if (k == 63) chk({tag, "_pre_lock"}, lock, 0);
    end
    chk({tag, "_lock"}, lock, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    sync  = 2'b00;
    clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_slip", slip, 0);
    chk("rst_lock", lock, 0);
    chk("rst_hi_ber", hi_ber, 0);
    chk("rst_ber_cnt", ber_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean acquisition
    acquire("acq");
    chk("acq_no_slip", slip_seen, 0);

    // 15 invalid headers in one locked window: lock held
    for (int k = 1; k <= 64; k++) begin
      send(1'b1, (k <= 15) ? (k[0] ? 2'b00 : 2'b11) : hdr(k), 1'b0);
    end
    chk("inv15_lock", lock, 1);
    chk("inv15_no_slip", slip_seen, 0);
    chk("inv15_ber_cnt", ber_cnt, 15);
    chk("inv15_hi_ber", hi_ber, 0);

    // 16 invalid headers: lock lost; BER window total passes 16 on the first
    for (int k = 1; k <= 16; k++) begin
      send(1'b1, 2'b00, 1'b0);
      if (k == 1)  chk("inv16_hi_ber_set", hi_ber, 1);
      if (k == 15) chk("inv16_lock_held", lock, 1);
    end
    chk("inv16_lock_lost", lock, 0);
    chk("inv16_slip", slip, 1);
    chk("inv16_ber_cnt", ber_cnt, 31);
    chk("inv16_hi_ber_clr", hi_ber, 0);
    send(1'b1, 2'b11, 1'b0);
    chk("inv16_slip_width", slip, 0);
    chk("inv16_slip_count", slip_seen, 1);

    // HUNT slip on block 5, two ignored bad headers, then clean lock
    do_reset();
    for (int k = 1; k <= 4; k++) send(1'b1, hdr(k), 1'b0);
    send(1'b1, 2'b00, 1'b0);
    chk("hunt_slip", slip, 1);
    send(1'b1, 2'b11, 1'b0);
    chk("wait1_no_slip", slip, 0);
    send(1'b1, 2'b11, 1'b0);
    chk("wait2_no_slip", slip, 0);
    acquire("reacq");
    chk("reacq_slip_count", slip_seen, 1);

    // Stall one cycle in 33 during acquisition, garbage header on stalls
    do_reset();
    begin
      int nv;
      nv = 0;
      for (int c = 0; c < 200 && nv < 64; c++) begin
        if ((c % 33) == 32) begin
          send(1'b0, 2'b00, 1'b0);
          chk("stall_no_lock", lock, 0);
          chk("stall_no_slip", slip, 0);
        end else begin
          nv++;
          send(1'b1, hdr(nv), 1'b0);
          if (nv == 63) chk("stall_pre_lock", lock, 0);
        end
      end
    end
    chk("stall_lock", lock, 1);
    chk("stall_slip_count", slip_seen, 0);

    // BER: 8 invalids in each of two locked windows within one BER window
    do_reset();
    acquire("ber_acq");
    for (int n = 65; n <= 192; n++) begin
      send(1'b1, (((n - 65) % 8) == 0) ? 2'b00 : hdr(n), 1'b0);
      if (n == 177) chk("ber_15_hi_ber", hi_ber, 0);
      if (n == 185) chk("ber_16_hi_ber", hi_ber, 1);
    end
    chk("ber_lock_held", lock, 1);
    chk("ber_cnt_16", ber_cnt, 16);
    chk("ber_no_slip", slip_seen, 0);
    // First BER window ends at block 264 with 16 counted; next is clean.
    for (int n = 193; n <= 464; n++) begin
      send(1'b1, hdr(n), 1'b0);
      if (n == 264) chk("ber_win1_end", hi_ber, 1);
      if (n == 463) chk("ber_win2_last", hi_ber, 1);
      if (n == 464) chk("ber_win2_end", hi_ber, 0);
    end

    // Clear coinciding with a locked invalid header
    send(1'b1, 2'b00, 1'b1);
    chk("clr_with_inv", ber_cnt, 1);
    send(1'b1, 2'b11, 1'b0);
    chk("clr_then_inv", ber_cnt, 2);
    chk("pre_arst_lock", lock, 1);

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_slip", slip, 0);
    chk("arst_lock", lock, 0);
    chk("arst_hi_ber", hi_ber, 0);
    chk("arst_ber_cnt", ber_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
